mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register in the 16-bit CPU pipeline.
- Takes the latched EX/MEM control and data, runs the data-memory access with a req/ack handshake, and resolves branches by driving branched and pcTarget back upstream.
- Freezes upstream with stall while memory is busy, and loads the MEM/WB writeback outputs.

Parameters:
TIMEOUT, 15, max cycles in ACCESS without memAck before abort (1..255)

Ports:
clk  input  1  clock; block updates on rising edge (EX/MEM updates on falling edge, so inputs are stable here)
reset  input  1  asynchronous, active-high
CregWrite  input  2  00 none, 01 write wbDest, 10 write wbDest plus R0 pair, 11 treated as 00
CmemWrite  input  2  00 none, 01 store word, 10 store low byte, 11 treated as 00
CmemToReg  input  1  load: writeback data comes from memory
Cbranch  input  1  branch taken in EX
Finresult  input  16  ALU result / memory address
Finbranch  input  16  branch target
R1data  input  16  store data
FinR0  input  16  secondary result (R0 pair)
FwriteBack  input  4  destination register
memAck  input  1  memory completion, one-cycle pulse
memRdata  input  16  load data, valid with memAck
memReq  output  1  memory request, held until ack/abort
memWe  output  1  1 store, 0 load
memAddr  output  16  access address
memWdata  output  16  store data
memByteEn  output  2  11 word, 01 low byte
stall  output  1  upstream hold
branched  output  1  one-cycle flush pulse
pcTarget  output  16  PC load value, valid with branched
wbRegWrite  output  2  MEM/WB write control
wbDest  output  4  MEM/WB destination
wbData  output  16  MEM/WB data
wbR0  output  16  MEM/WB R0 pair data
memErr  output  1  sticky: access timed out

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0: memReq, memWe, memAddr, memWdata, memByteEn, stall, branched, pcTarget, wbRegWrite, wbDest, wbData, wbR0, memErr. Timeout counter 0.
- Reset during ACCESS: memReq drops immediately and the access is discarded. No writeback occurs.
- States: IDLE, ACCESS. stall = (state == ACCESS), registered.
- IDLE, per rising edge, inputs sampled:
  - Cbranch=1: branched=1, pcTarget=Finbranch, wbRegWrite=0 for one cycle. Any CmemWrite/CmemToReg in the same cycle is suppressed; branch wins.
  - Memory op (CmemWrite in {01,10} or CmemToReg=1, and Cbranch=0): memReq=1, memAddr=Finresult.
    - Store: memWe=1 and no writeback. 01: memWdata=R1data, memByteEn=11. 10: memWdata={8'h00,R1data[7:0]}, memByteEn=01.
    - Load (CmemToReg=1, CmemWrite=00): memWe=0, memByteEn=11.
    - CmemWrite and CmemToReg both set: store wins, writeback suppressed.
    - Latch CregWrite, FwriteBack, FinR0. Counter=0. Go to ACCESS. wbRegWrite=0 this cycle.
  - Otherwise, ALU pass-through (1-cycle latency): wbRegWrite=CregWrite (11 maps to 00), wbDest=FwriteBack, wbData=Finresult, wbR0=FinR0.
  - All-zero control is a bubble: wbRegWrite=0, wbDest/wbData/wbR0 hold.
- branched is high for exactly one cycle per taken branch. Back-to-back branch inputs give back-to-back pulses.
- ACCESS:
  - memReq, memWe, memAddr, memWdata, memByteEn hold stable. Counter increments each cycle without memAck.
  - memAck=1: memReq=0, go to IDLE.
    - Load: wbRegWrite=latched value, wbDest=latched, wbData=memRdata, wbR0=latched.
    - Store: wbRegWrite=0.
    - stall falls on the same edge. The next instruction is sampled on the following edge.
  - Counter reaches TIMEOUT-1 with memAck=0: abort. memReq=0, memErr=1 (sticky until reset), wbRegWrite=0, go to IDLE.
  - memAck on the same edge as timeout: ack wins, no error.
  - Inputs (including Cbranch) are ignored while in ACCESS; upstream is held by stall.
- memAck while in IDLE is ignored.
- wbRegWrite is nonzero for at most one cycle per instruction.

Test Plan:
- ALU pass-through: CregWrite=01, FwriteBack=4'h3, Finresult=16'h1234, no mem/branch -> next edge wbRegWrite=01, wbDest=3, wbData=1234; stall stays 0.
- Load with 3-cycle memory: CmemToReg=1, CregWrite=01, Finresult=16'h0040, ack 3 cycles after req with memRdata=16'hBEEF -> memReq=1, memWe=0, memAddr=0040, stall=1 for 3 cycles; then wbData=BEEF, wbDest latched, stall=0.
- Byte store: CmemWrite=10, R1data=16'hA5C3, Finresult=16'h0010, ack next cycle -> memWe=1, memWdata=00C3, memByteEn=01, wbRegWrite=0.
- Branch with concurrent store: Cbranch=1, Finbranch=16'h0200, CmemWrite=01 -> branched=1 for exactly one cycle, pcTarget=0200, memReq never asserts.
- Timeout: TIMEOUT=4, load, no ack -> memReq high 4 cycles, then memReq=0, memErr=1, wbRegWrite=0, state IDLE. Repeat with ack on the 4th cycle -> memErr=0 and load completes.
- Async reset mid-ACCESS: raise reset between edges during a pending load -> memReq, stall, and all wb outputs go 0 immediately; no writeback after reset release.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the data-memory req/ack access, resolves branches
// and loads the MEM/WB writeback register from the latched EX/MEM fields.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  CregWrite,
    input  logic [1:0]  CmemWrite,
    input  logic        CmemToReg,
    input  logic        Cbranch,
    input  logic [15:0] Finresult,
    input  logic [15:0] Finbranch,
    input  logic [15:0] R1data,
    input  logic [15:0] FinR0,
    input  logic [3:0]  FwriteBack,
    input  logic        memAck,
    input  logic [15:0] memRdata,
    output logic        memReq,
    output logic        memWe,
    output logic [15:0] memAddr,
    output logic [15:0] memWdata,
    output logic [1:0]  memByteEn,
    output logic        stall,
    output logic        branched,
    output logic [15:0] pcTarget,
    output logic [1:0]  wbRegWrite,
    output logic [3:0]  wbDest,
    output logic [15:0] wbData,
    output logic [15:0] wbR0,
    output logic        memErr
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lat_regw_q, lat_regw_d;
    logic [3:0]  lat_dest_q, lat_dest_d;
    logic [15:0] lat_r0_q, lat_r0_d;
    logic        lat_load_q, lat_load_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic        stall_q, stall_d;
    logic        branched_q, branched_d;
    logic [15:0] pc_target_q, pc_target_d;
    logic [1:0]  wb_regw_q, wb_regw_d;
    logic [3:0]  wb_dest_q, wb_dest_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [15:0] wb_r0_q, wb_r0_d;
    logic        mem_err_q, mem_err_d;

    logic        is_store;
    logic        is_load;
    logic [1:0]  regw_eff;

    // Encoding 11 on either control field is a no-op.
    assign is_store = (CmemWrite == 2'b01) || (CmemWrite == 2'b10);
    assign is_load  = CmemToReg && !is_store;
    assign regw_eff = (CregWrite == 2'b11) ? 2'b00 : CregWrite;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_regw_d  = lat_regw_q;
        lat_dest_d  = lat_dest_q;
        lat_r0_d    = lat_r0_q;
        lat_load_d  = lat_load_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        branched_d  = 1'b0;
        pc_target_d = pc_target_q;
        wb_regw_d   = 2'b00;
        wb_dest_d   = wb_dest_q;
        wb_data_d   = wb_data_q;
        wb_r0_d     = wb_r0_q;
        mem_err_d   = mem_err_q;

        case (state_q)
            IDLE: begin
                if (Cbranch) begin
                    branched_d  = 1'b1;
                    pc_target_d = Finbranch;
                end else if (is_store || is_load) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = Finresult;
                    mem_we_d   = is_store;
                    mem_be_d   = 2'b11;
                    if (CmemWrite == 2'b10) begin
                        mem_wdata_d = {8'h00, R1data[7:0]};
                        mem_be_d    = 2'b01;
                    end else if (is_store) begin
                        mem_wdata_d = R1data;
                    end
                    lat_regw_d = regw_eff;
                    lat_dest_d = FwriteBack;
                    lat_r0_d   = FinR0;
                    lat_load_d = is_load;
                    cnt_d      = 8'd0;
                    state_d    = ACCESS;
                end else if (regw_eff != 2'b00) begin
                    wb_regw_d = regw_eff;
                    wb_dest_d = FwriteBack;
                    wb_data_d = Finresult;
                    wb_r0_d   = FinR0;
                end
            end
            ACCESS: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (lat_load_q) begin
                        wb_regw_d = lat_regw_q;
                        wb_dest_d = lat_dest_q;
                        wb_data_d = memRdata;
                        wb_r0_d   = lat_r0_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d == ACCESS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            lat_regw_q  <= 2'b00;
            lat_dest_q  <= 4'h0;
            lat_r0_q    <= 16'h0000;
            lat_load_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            mem_be_q    <= 2'b00;
            stall_q     <= 1'b0;
            branched_q  <= 1'b0;
            pc_target_q <= 16'h0000;
            wb_regw_q   <= 2'b00;
            wb_dest_q   <= 4'h0;
            wb_data_q   <= 16'h0000;
            wb_r0_q     <= 16'h0000;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_regw_q  <= lat_regw_d;
            lat_dest_q  <= lat_dest_d;
            lat_r0_q    <= lat_r0_d;
            lat_load_q  <= lat_load_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            stall_q     <= stall_d;
            branched_q  <= branched_d;
            pc_target_q <= pc_target_d;
            wb_regw_q   <= wb_regw_d;
            wb_dest_q   <= wb_dest_d;
            wb_data_q   <= wb_data_d;
            wb_r0_q     <= wb_r0_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign memReq     = mem_req_q;
    assign memWe      = mem_we_q;
    assign memAddr    = mem_addr_q;
    assign memWdata   = mem_wdata_q;
    assign memByteEn  = mem_be_q;
    assign stall      = stall_q;
    assign branched   = branched_q;
    assign pcTarget   = pc_target_q;
    assign wbRegWrite = wb_regw_q;
    assign wbDest     = wb_dest_q;
    assign wbData     = wb_data_q;
    assign wbR0       = wb_r0_q;
    assign memErr     = mem_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed plan cases plus randomized instructions, each
// checked against a per-instruction outcome model (latency, writeback, abort).
module tb_mem_stage_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  CregWrite, CmemWrite;
    logic        CmemToReg, Cbranch;
    logic [15:0] Finresult, Finbranch, R1data, FinR0;
    logic [3:0]  FwriteBack;
    logic        memAck;
    logic [15:0] memRdata;
    logic        memReq, memWe, stall, branched, memErr;
    logic [15:0] memAddr, memWdata, pcTarget, wbData, wbR0;
    logic [1:0]  memByteEn, wbRegWrite;
    logic [3:0]  wbDest;

    int n_checks = 0;
    int n_fail = 0;
    logic model_err = 1'b0;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .CregWrite(CregWrite), .CmemWrite(CmemWrite), .CmemToReg(CmemToReg),
        .Cbranch(Cbranch), .Finresult(Finresult), .Finbranch(Finbranch),
        .R1data(R1data), .FinR0(FinR0), .FwriteBack(FwriteBack),
        .memAck(memAck), .memRdata(memRdata),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memByteEn(memByteEn), .stall(stall), .branched(branched), .pcTarget(pcTarget),
        .wbRegWrite(wbRegWrite), .wbDest(wbDest), .wbData(wbData), .wbR0(wbR0),
        .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] rw, input logic [1:0] mw, input logic tr,
                         input logic br, input logic [15:0] res, input logic [15:0] brt,
                         input logic [15:0] r1, input logic [15:0] r0, input logic [3:0] dst);
        CregWrite = rw; CmemWrite = mw; CmemToReg = tr; Cbranch = br;
        Finresult = res; Finbranch = brt; R1data = r1; FinR0 = r0; FwriteBack = dst;
    endtask

    // One instruction from issue to retirement. ack_delay = cycles after request
    // until memAck; anything beyond TO means the memory never answers.
    task automatic do_instr(input logic [1:0] rw, input logic [1:0] mw, input logic tr,
                            input logic br, input logic [15:0] res, input logic [15:0] brt,
                            input logic [15:0] r1, input logic [15:0] r0, input logic [3:0] dst,
                            input int ack_delay, input logic [15:0] rdata);
        bit st, ld;
        logic [1:0] rw_eff;
        logic [15:0] exp_wdata;
        logic [1:0] exp_be;
        st = (mw == 2'd1) || (mw == 2'd2);
        ld = tr && !st;
        rw_eff = (rw == 2'd3) ? 2'd0 : rw;
        exp_wdata = (mw == 2'd2) ? {8'h00, r1[7:0]} : r1;
        exp_be = (mw == 2'd2) ? 2'b01 : 2'b11;
        drive(rw, mw, tr, br, res, brt, r1, r0, dst);
        memAck = 1'b0;
        tick();
        check("memErr", memErr, model_err);
        if (br) begin
            check("br_branched", branched, 1);
            check("br_pcTarget", pcTarget, brt);
            check("br_memReq", memReq, 0);
            check("br_wbRegWrite", wbRegWrite, 0);
            check("br_stall", stall, 0);
        end else if (st || ld) begin
            check("req_memReq", memReq, 1);
            check("req_memWe", memWe, st);
            check("req_memAddr", memAddr, res);
            if (st) check("req_memWdata", memWdata, exp_wdata);
            check("req_memByteEn", memByteEn, ld ? 2'b11 : exp_be);
            check("req_stall", stall, 1);
            check("req_wbRegWrite", wbRegWrite, 0);
            check("req_branched", branched, 0);
            for (int k = 1; k <= int'(TO); k++) begin
                // Upstream noise while stalled must be ignored.
                drive(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                      16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      4'($urandom));
                memAck = (k == ack_delay);
                memRdata = (k == ack_delay) ? rdata : 16'($urandom);
                tick();
                memAck = 1'b0;
                if (k == ack_delay) begin
                    check("ack_memReq", memReq, 0);
                    check("ack_stall", stall, 0);
                    check("ack_wbRegWrite", wbRegWrite, ld ? rw_eff : 2'd0);
                    if (ld && rw_eff != 2'd0) begin
                        check("ack_wbDest", wbDest, dst);
                        check("ack_wbData", wbData, rdata);
                        check("ack_wbR0", wbR0, r0);
                    end
                    check("ack_memErr", memErr, model_err);
                    break;
                end else if (k == int'(TO)) begin
                    model_err = 1'b1;
                    check("to_memReq", memReq, 0);
                    check("to_stall", stall, 0);
                    check("to_wbRegWrite", wbRegWrite, 0);
                    check("to_memErr", memErr, 1);
                end else begin
                    check("wait_memReq", memReq, 1);
                    check("wait_stall", stall, 1);
                    check("wait_memAddr", memAddr, res);
                    if (st) check("wait_memWdata", memWdata, exp_wdata);
                    check("wait_branched", branched, 0);
                    check("wait_wbRegWrite", wbRegWrite, 0);
                end
            end
        end else begin
            check("alu_wbRegWrite", wbRegWrite, rw_eff);
            if (rw_eff != 2'd0) begin
                check("alu_wbDest", wbDest, dst);
                check("alu_wbData", wbData, res);
                check("alu_wbR0", wbR0, r0);
            end
            check("alu_stall", stall, 0);
            check("alu_memReq", memReq, 0);
            check("alu_branched", branched, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        memAck = 1'b0;
        memRdata = 16'h0;
        #2;
        check("rst_memReq", memReq, 0);
        check("rst_stall", stall, 0);
        check("rst_branched", branched, 0);
        check("rst_pcTarget", pcTarget, 0);
        check("rst_wb", {wbRegWrite, wbDest, wbData}, 0);
        check("rst_mem", {memWe, memAddr, memWdata, memByteEn}, 0);
        check("rst_memErr", memErr, 0);
        tick();
        tick();
        reset = 1'b0;

        // ALU pass-through
        do_instr(2'd1, 2'd0, 1'b0, 1'b0, 16'h1234, 16'h0, 16'h0, 16'h5555, 4'h3, 0, 16'h0);
        // Load, 3-cycle memory
        do_instr(2'd1, 2'd0, 1'b1, 1'b0, 16'h0040, 16'h0, 16'h0, 16'h0777, 4'h6, 3, 16'hBEEF);
        // Byte store, ack next cycle
        do_instr(2'd1, 2'd2, 1'b0, 1'b0, 16'h0010, 16'h0, 16'hA5C3, 16'h0, 4'h2, 1, 16'h0);
        // Branch beats a concurrent store, then back-to-back branches
        do_instr(2'd1, 2'd1, 1'b0, 1'b1, 16'h0030, 16'h0200, 16'h1111, 16'h0, 4'h1, 0, 16'h0);
        do_instr(2'd0, 2'd0, 1'b1, 1'b1, 16'h0031, 16'h0300, 16'h0, 16'h0, 4'h1, 0, 16'h0);
        do_instr(2'd0, 2'd0, 1'b0, 1'b1, 16'h0032, 16'h0404, 16'h0, 16'h0, 4'h1, 0, 16'h0);
        do_instr(2'd2, 2'd0, 1'b0, 1'b0, 16'h4321, 16'h0, 16'h0, 16'h9876, 4'hA, 0, 16'h0);
        // Load and store with both flags: store wins
        do_instr(2'd1, 2'd1, 1'b1, 1'b0, 16'h0050, 16'h0, 16'hCAFE, 16'h0, 4'h7, 2, 16'h1357);
        // Ack on the deadline cycle completes; then no ack at all aborts
        do_instr(2'd2, 2'd0, 1'b1, 1'b0, 16'h0060, 16'h0, 16'h0, 16'h2468, 4'h9, int'(TO), 16'hD00D);
        do_instr(2'd1, 2'd0, 1'b1, 1'b0, 16'h0070, 16'h0, 16'h0, 16'h0, 4'h4, int'(TO) + 1, 16'h0);

        // Stray ack in IDLE
        drive(2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        check("idleack_memReq", memReq, 0);
        check("idleack_stall", stall, 0);
        check("idleack_wbRegWrite", wbRegWrite, 0);

        for (int i = 0; i < 40; i++) begin
            do_instr(2'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                     16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                     int'($urandom_range(1, TO + 2)), 16'($urandom));
        end

        // Async reset in the middle of a pending load
        drive(2'd1, 2'd0, 1'b1, 1'b0, 16'h0080, 16'h0, 16'h0, 16'h0, 4'h5);
        tick();
        check("prst_memReq", memReq, 1);
        drive(2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        tick();
        #3;
        reset = 1'b1;
        #1;
        model_err = 1'b0;
        check("arst_memReq", memReq, 0);
        check("arst_stall", stall, 0);
        check("arst_wb", {wbRegWrite, wbDest, wbData}, 0);
        check("arst_wbR0", wbR0, 0);
        check("arst_memErr", memErr, 0);
        #2;
        reset = 1'b0;
        memAck = 1'b1;
        memRdata = 16'hFACE;
        tick();
        memAck = 1'b0;
        check("post_wbRegWrite", wbRegWrite, 0);
        check("post_memReq", memReq, 0);
        check("post_stall", stall, 0);
        tick();
        check("post2_wbRegWrite", wbRegWrite, 0);
        check("post2_memErr", memErr, model_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
